arb_requester: RTL and testbench
================================

Name: arb_requester

Overview:
- Client-side agent for one port of the round-robin arbiter.
- Buffers upstream packet beats, drives one req bit to the arbiter and consumes the matching grant bit.
- Forwards one beat per granted cycle onto a shared output bus, with a registered output stage.
- Enforces a one-cycle request holdoff at packet boundaries and monitors starvation.
- One instance per arbiter request line; the instance's grant input is its own bit of the arbiter's one-hot grant vector.

Parameters:
- DATA_W, 8, beat payload width.
- DEPTH, 4, beat FIFO depth; must be a power of two and at least 2.
- STARVE_LIMIT, 32, consecutive denied-request cycles before starve asserts; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  upstream ready; equals FIFO not full.
- in_data  in  DATA_W  upstream beat payload.
- in_last  in  1  final beat of packet.
- req  out  1  request to arbiter.
- grant  in  1  this client's grant bit, combinational from arbiter in the same cycle as req.
- out_valid  out  1  beat forwarded this cycle.
- out_data  out  DATA_W  forwarded payload.
- out_last  out  1  forwarded beat is last of packet.
- starve  out  1  request pending STARVE_LIMIT cycles without grant.
- err  out  1  sticky protocol error: grant seen while req low.

Behaviour:
- Reset (async assert, sync release) values: FIFO empty, state IDLE, req=0, out_valid=0, out_data=0, out_last=0, starve=0, err=0, wait_cnt=0, in_ready=1.
- FIFO: DEPTH entries of {last, data}; count width $clog2(DEPTH+1).
  - Push when in_valid && in_ready.
  - Pop when req && grant.
  - Push and pop in the same cycle leave count unchanged.
  - No bypass: a beat pushed in cycle N can be requested no earlier than cycle N+1.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: FIFO empty, req=0. Go to REQ when count becomes nonzero.
  - REQ: req=1 (combinational from state).
    - On req&&grant with head.last=1, go to HOLDOFF.
    - On a pop that empties the FIFO with head.last=0, go to IDLE.
    - Otherwise stay in REQ.
  - HOLDOFF: req=0 for exactly one cycle, which releases the arbiter to other clients. Next state is REQ if count>0, else IDLE.
- Beat transfer latency is 1 cycle. On a req&&grant edge, out_valid=1 next cycle with the popped head's data and last; otherwise out_valid=0. out_data and out_last hold their last values when out_valid=0.
- Grant is honoured per cycle. The arbiter may move grant away mid-packet; the beat is not popped, and req stays high in REQ.
- wait_cnt:
  - Increments each cycle req && !grant, saturating at STARVE_LIMIT.
  - Clears to 0 on req && grant or when req=0.
  - starve = (wait_cnt == STARVE_LIMIT), registered; deasserts the cycle after a grant.
- err is set on grant && !req and cleared only by rst.
- Reset asserted mid-packet discards all buffered beats and drops req and out_valid immediately (async).

Decomposition:
- Shared package arb_pkg:
  - arb_state_e enum {IDLE, REQ, HOLDOFF}.
  - Parameterised beat struct typedef {last, data}.
  - Localparam helper for the count width.
  - arb_pkg is shared with the arbiter's bench.
- One sub-module, arb_req_fifo: synchronous FIFO with async reset, push/pop/full/empty/count and head-entry output (first-word fall-through).
- FSM, wait counter and output register live in arb_requester.

Test Plan:
- Reset then push single beat data=0xA5,last=1 with grant tied to req → req high the cycle after the push; out_valid=1, out_data=0xA5, out_last=1 one cycle later; next cycle req=0 (HOLDOFF), then IDLE.
- Push 4 beats 0x01..0x04 (last on 0x04) with DEPTH=4 → in_ready=0 after the 4th push; grant held high → outputs 0x01..0x04 on 4 consecutive cycles; req low one cycle after the 4th pop.
- Packet 0x10,0x11,0x12(last) with grant high, low, low, high, high → out_valid pattern 1,0,0,1,1 (delayed one cycle); req stays high through the gaps.
- STARVE_LIMIT=4, one beat buffered, grant held low 6 cycles → starve=1 from the 5th cycle after req rises; grant then high → starve=0 the cycle after the pop.
- grant pulsed while FIFO empty → err=1 and remains 1 until rst.
- Async rst asserted mid-cycle with 3 beats buffered and req high → req=0, out_valid=0, in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/arb_pkg.sv
// Types and helpers shared by the arbiter requester and the arbiter's bench.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLDOFF = 2'd2
  } arb_state_e;

  // Default-width beat. Blocks with a parameterised DATA_W declare the same
  // {last, data} layout locally at their own width.
  localparam int ARB_DATA_W = 8;

  typedef struct packed {
    logic                  last;
    logic [ARB_DATA_W-1:0] data;
  } arb_beat_t;

  // Width of an occupancy counter that must hold 0..depth inclusive.
  function automatic int arb_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Synchronous first-word-fall-through FIFO with async reset; head entry is
// visible on rdata whenever the FIFO is not empty.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 4,
  localparam int CNT_W = arb_cnt_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Client agent for one round-robin arbiter port: buffers beats, requests,
// forwards one beat per granted cycle and inserts a holdoff after each packet.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              req,
  input  logic              grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              starve,
  output logic              err
);

  localparam int CNT_W = arb_cnt_w(DEPTH);
  localparam int WC_W  = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t            in_beat;
  beat_t            head;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             cnt_nz_nxt;
  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [WC_W-1:0]  wait_cnt;
  logic [WC_W-1:0]  wait_cnt_nxt;

  assign in_beat  = '{last: in_last, data: in_data};
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign req      = (state == REQ);
  assign pop      = req && grant && !empty;

  arb_req_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_beat),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Outside REQ nothing pops, so next-cycle occupancy is nonzero iff either
  // something is buffered or a beat lands this cycle.
  assign cnt_nz_nxt = (count != '0) || push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cnt_nz_nxt) state_nxt = REQ;
      REQ: begin
        if (pop && head.last)
          state_nxt = HOLDOFF;
        else if (pop && (count == CNT_W'(1)) && !push)
          state_nxt = IDLE;
      end
      HOLDOFF: state_nxt = cnt_nz_nxt ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered output stage: one-cycle beat latency, payload held when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_data <= head.data;
        out_last <= head.last;
      end
    end
  end

  always_comb begin
    wait_cnt_nxt = '0;
    if (req && !grant)
      wait_cnt_nxt = (wait_cnt == WC_W'(STARVE_LIMIT)) ? wait_cnt : wait_cnt + 1'b1;
  end

  // starve tracks the counter value it is registered alongside, so it drops
  // the cycle after a grant clears the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      starve   <= (wait_cnt_nxt == WC_W'(STARVE_LIMIT));
      if (grant && !req) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed vector bench for arb_requester: per-cycle table plus async reset check.
module tb_arb_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       req;
  logic       grant;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       starve;
  logic       err;
  logic       g_follow;
  logic       g_force;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Grant either mirrors req (arbiter always picks us) or is forced high.
  assign grant = g_force | (g_follow & req);

  arb_requester #(.DATA_W(8), .DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .starve    (starve),
    .err       (err)
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       l;
    logic       f;
    logic       gf;
    logic       e_req;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ol;
    logic       e_ir;
    logic       e_st;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [7:0] d, logic l, logic f, logic gf,
                              logic rq, logic ov, logic [7:0] od, logic ol,
                              logic ir, logic st, logic er);
    vec_t v;
    v.iv = iv; v.d = d; v.l = l; v.f = f; v.gf = gf;
    v.e_req = rq; v.e_ov = ov; v.e_od = od; v.e_ol = ol;
    v.e_ir = ir; v.e_st = st; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic rq, input logic ov, input logic [7:0] od,
                            input logic ol, input logic ir, input logic st, input logic er);
    chk("req",       idx, 32'(req),       32'(rq));
    chk("out_valid", idx, 32'(out_valid), 32'(ov));
    chk("out_data",  idx, 32'(out_data),  32'(od));
    chk("out_last",  idx, 32'(out_last),  32'(ol));
    chk("in_ready",  idx, 32'(in_ready),  32'(ir));
    chk("starve",    idx, 32'(starve),    32'(st));
    chk("err",       idx, 32'(err),       32'(er));
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0; g_follow = 0; g_force = 0;

    // single beat, grant follows req
    tbl.push_back(mk(1,8'hA5,1,1,0, 0,0,8'h00,0,1,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 1,0,8'h00,0,1,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 0,1,8'hA5,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 0,0,8'hA5,1,1,0,0));
    // fill to full with grant low, then drain back-to-back
    tbl.push_back(mk(1,8'h01,0,0,0, 0,0,8'hA5,1,1,0,0));
    tbl.push_back(mk(1,8'h02,0,0,0, 1,0,8'hA5,1,1,0,0));
    tbl.push_back(mk(1,8'h03,0,0,0, 1,0,8'hA5,1,1,0,0));
    tbl.push_back(mk(1,8'h04,1,0,0, 1,0,8'hA5,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 1,0,8'hA5,1,0,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 1,1,8'h01,0,1,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 1,1,8'h02,0,1,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 1,1,8'h03,0,1,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 0,1,8'h04,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 0,0,8'h04,1,1,0,0));
    // grant gaps mid-packet: 1,0,0,1,1
    tbl.push_back(mk(1,8'h10,0,0,0, 0,0,8'h04,1,1,0,0));
    tbl.push_back(mk(1,8'h11,0,0,0, 1,0,8'h04,1,1,0,0));
    tbl.push_back(mk(1,8'h12,1,0,0, 1,0,8'h04,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 1,0,8'h04,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 1,1,8'h10,0,1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 1,0,8'h10,0,1,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 1,0,8'h10,0,1,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 1,1,8'h11,0,1,0,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 0,1,8'h12,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 0,0,8'h12,1,1,0,0));
    // starvation with limit 4, then grant
    tbl.push_back(mk(1,8'h33,1,0,0, 0,0,8'h12,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 1,0,8'h12,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 1,0,8'h12,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 1,0,8'h12,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 1,0,8'h12,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 1,0,8'h12,1,1,1,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 1,0,8'h12,1,1,1,0));
    tbl.push_back(mk(0,8'h00,0,1,0, 1,0,8'h12,1,1,1,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 0,1,8'h33,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 0,0,8'h33,1,1,0,0));
    // grant while not requesting: sticky err
    tbl.push_back(mk(0,8'h00,0,0,1, 0,0,8'h33,1,1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0, 0,0,8'h33,1,1,0,1));
    tbl.push_back(mk(0,8'h00,0,0,0, 0,0,8'h33,1,1,0,1));
    // buffer a packet and forward its first beat ahead of the async reset
    tbl.push_back(mk(1,8'h20,0,0,0, 0,0,8'h33,1,1,0,1));
    tbl.push_back(mk(1,8'h21,0,0,0, 1,0,8'h33,1,1,0,1));
    tbl.push_back(mk(1,8'h22,0,0,0, 1,0,8'h33,1,1,0,1));
    tbl.push_back(mk(1,8'h23,1,0,0, 1,0,8'h33,1,1,0,1));
    tbl.push_back(mk(0,8'h00,0,1,0, 1,0,8'h33,1,0,0,1));
    tbl.push_back(mk(0,8'h00,0,0,0, 1,1,8'h20,0,1,0,1));

    #1;
    check_outs(-1, 0,0,8'h00,0,1,0,0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      in_valid = tbl[i].iv; in_data = tbl[i].d; in_last = tbl[i].l;
      g_follow = tbl[i].f;  g_force = tbl[i].gf;
      @(negedge clk);
      check_outs(i, tbl[i].e_req, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_ol,
                 tbl[i].e_ir, tbl[i].e_st, tbl[i].e_err);
    end

    // Mid-cycle async reset: outputs must drop without a clock edge.
    #2 rst = 1'b1;
    #1;
    check_outs(100, 0,0,8'h00,0,1,0,0);
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 0; g_follow = 1; g_force = 0;
    // buffered beats were discarded, so no request follows release
    repeat (2) begin
      @(negedge clk);
      check_outs(101, 0,0,8'h00,0,1,0,0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
